// File: rtl/vga_fb_pkg.sv
// Shared sizing helpers and clear-engine state encoding for the (x, y) addressed frame buffer.
package vga_fb_pkg;

    localparam int unsigned DEF_PIX_W = 12;
    localparam int unsigned DEF_H_RES = 320;
    localparam int unsigned DEF_V_RES = 240;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned width_for(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned bank_words(input int unsigned h_res, input int unsigned v_res);
        return h_res * v_res;
    endfunction

    function automatic int unsigned addr_width(input int unsigned h_res, input int unsigned v_res,
                                               input int unsigned double_buf);
        return width_for(bank_words(h_res, v_res) * ((double_buf != 0) ? 2 : 1));
    endfunction

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_FILL = 1'b1
    } clr_state_e;

endpackage

// File: rtl/fb_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module fb_sdp_ram #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_framebuf.sv
// Frame buffer between camera capture and VGA scan-out: (x, y) addressing,
// optional double buffering swapped at display frame start, and a back-bank clear engine.
module vga_framebuf
    import vga_fb_pkg::*;
#(
    parameter int unsigned PIX_W      = DEF_PIX_W,
    parameter int unsigned H_RES      = DEF_H_RES,
    parameter int unsigned V_RES      = DEF_V_RES,
    parameter int unsigned DOUBLE_BUF = 1,
    localparam int unsigned X_W       = width_for(H_RES),
    localparam int unsigned Y_W       = width_for(V_RES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic [PIX_W-1:0] wr_pix,
    input  logic             wr_eof,
    input  logic             rd_en,
    input  logic [X_W-1:0]   rd_x,
    input  logic [Y_W-1:0]   rd_y,
    input  logic             rd_vsync,
    output logic             rd_valid,
    output logic [PIX_W-1:0] rd_pix,
    input  logic             clr_start,
    input  logic [PIX_W-1:0] clr_color,
    output logic             clr_busy,
    output logic             swap_pending,
    output logic             frame_drop,
    output logic             oob_err
);

    localparam int unsigned N      = bank_words(H_RES, V_RES);
    localparam int unsigned DEPTH  = N * ((DOUBLE_BUF != 0) ? 2 : 1);
    localparam int unsigned ADDR_W = addr_width(H_RES, V_RES, DOUBLE_BUF);
    localparam int unsigned CNT_W  = width_for(N);

    clr_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PIX_W-1:0]   color_q, color_d;

    logic               front_q, front_d, back_q, back_d;
    logic               wr_ready_q, wr_ready_d;
    logic               clr_busy_q, clr_busy_d;
    logic               pending_q, pending_d;
    logic               drop_q, drop_d;
    logic               oob_q, oob_d;

    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [PIX_W-1:0]   wdata_q, wdata_d;

    logic               rv1_q, rv2_q, roob1_q, roob2_q, roob1_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic               rd_valid_q;
    logic [PIX_W-1:0]   rd_pix_q, rd_pix_d;
    logic [PIX_W-1:0]   ram_rdata;

    logic               wr_acc, wr_oob, eof_acc, swap;
    logic [ADDR_W-1:0]  back_base, front_base;

    // Clear engine: walks the back bank once, one word per cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        case (state_q)
            CLR_IDLE: begin
                if (clr_start && !pending_q) begin
                    state_d = CLR_FILL;
                    cnt_d   = '0;
                    color_d = clr_color;
                end
            end
            CLR_FILL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = CLR_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    // Write staging, bank bookkeeping and status flags.
    always_comb begin
        wr_acc     = wr_valid && wr_ready_q;
        wr_oob     = (32'(wr_x) >= H_RES) || (32'(wr_y) >= V_RES);
        eof_acc    = wr_acc && wr_eof;
        swap       = rd_vsync && pending_q;
        back_base  = back_q  ? ADDR_W'(N) : '0;
        front_base = front_q ? ADDR_W'(N) : '0;

        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (state_q == CLR_FILL) begin
            we_d    = 1'b1;
            waddr_d = back_base + ADDR_W'(cnt_q);
            wdata_d = color_q;
        end else if (wr_acc && !wr_oob) begin
            we_d    = 1'b1;
            waddr_d = back_base + ADDR_W'(wr_y) * ADDR_W'(H_RES) + ADDR_W'(wr_x);
            wdata_d = wr_pix;
        end

        front_d = front_q;
        back_d  = back_q;
        if (swap && (DOUBLE_BUF != 0)) begin
            front_d = back_q;
            back_d  = front_q;
        end

        // A swap consumes the pending frame, so an eof that same cycle starts a fresh one.
        pending_d  = (pending_q && !rd_vsync) || eof_acc;
        drop_d     = eof_acc && pending_q && !rd_vsync;

        roob1_d    = (32'(rd_x) >= H_RES) || (32'(rd_y) >= V_RES);
        raddr_d    = front_base + ADDR_W'(rd_y) * ADDR_W'(H_RES) + ADDR_W'(rd_x);
        oob_d      = oob_q || (wr_acc && wr_oob) || (rd_en && roob1_d);

        rd_pix_d   = rd_pix_q;
        if (rv2_q) begin
            rd_pix_d = roob2_q ? '0 : ram_rdata;
        end

        wr_ready_d = (state_d == CLR_IDLE);
        clr_busy_d = (state_d == CLR_FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLR_IDLE;
            cnt_q      <= '0;
            color_q    <= '0;
            front_q    <= 1'b0;
            back_q     <= (DOUBLE_BUF != 0);
            wr_ready_q <= 1'b0;
            clr_busy_q <= 1'b0;
            pending_q  <= 1'b0;
            drop_q     <= 1'b0;
            oob_q      <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            rv1_q      <= 1'b0;
            rv2_q      <= 1'b0;
            roob1_q    <= 1'b0;
            roob2_q    <= 1'b0;
            raddr_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_pix_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            color_q    <= color_d;
            front_q    <= front_d;
            back_q     <= back_d;
            wr_ready_q <= wr_ready_d;
            clr_busy_q <= clr_busy_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            oob_q      <= oob_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            rv1_q      <= rd_en;
            rv2_q      <= rv1_q;
            roob1_q    <= rd_en && roob1_d;
            roob2_q    <= roob1_q;
            raddr_q    <= rd_en ? raddr_d : raddr_q;
            rd_valid_q <= rv2_q;
            rd_pix_q   <= rd_pix_d;
        end
    end

    fb_sdp_ram #(
        .DATA_W (PIX_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we_q),
        .waddr_i (waddr_q),
        .wdata_i (wdata_q),
        .re_i    (rv1_q),
        .raddr_i (raddr_q),
        .rdata_o (ram_rdata)
    );

    assign wr_ready     = wr_ready_q;
    assign clr_busy     = clr_busy_q;
    assign swap_pending = pending_q;
    assign frame_drop   = drop_q;
    assign oob_err      = oob_q;
    assign rd_valid     = rd_valid_q;
    assign rd_pix       = rd_pix_q;

endmodule

// File: tb/tb_vga_framebuf.sv
// Directed bench for vga_framebuf on a 6x5 double-buffered frame (30 words per bank).
module tb_vga_framebuf;

    localparam int unsigned PIX_W = 12;
    localparam int unsigned H_RES = 6;
    localparam int unsigned V_RES = 5;
    localparam int unsigned N     = H_RES * V_RES;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid, wr_ready, wr_eof;
    logic [2:0]       wr_x, rd_x;
    logic [2:0]       wr_y, rd_y;
    logic [PIX_W-1:0] wr_pix, rd_pix, clr_color;
    logic             rd_en, rd_vsync, rd_valid;
    logic             clr_start, clr_busy, swap_pending, frame_drop, oob_err;

    int checks = 0;
    int errors = 0;

    vga_framebuf #(
        .PIX_W      (PIX_W),
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .DOUBLE_BUF (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_pix       (wr_pix),
        .wr_eof       (wr_eof),
        .rd_en        (rd_en),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_vsync     (rd_vsync),
        .rd_valid     (rd_valid),
        .rd_pix       (rd_pix),
        .clr_start    (clr_start),
        .clr_color    (clr_color),
        .clr_busy     (clr_busy),
        .swap_pending (swap_pending),
        .frame_drop   (frame_drop),
        .oob_err      (oob_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int x, input int y, input int pix, input logic eof);
        wr_valid = 1'b1;
        wr_x     = 3'(x);
        wr_y     = 3'(y);
        wr_pix   = 12'(pix);
        wr_eof   = eof;
        tick();
        wr_valid = 1'b0;
        wr_eof   = 1'b0;
    endtask

    task automatic vsync();
        rd_vsync = 1'b1;
        tick();
        rd_vsync = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int x, input int y, input int exp);
        rd_en = 1'b1;
        rd_x  = 3'(x);
        rd_y  = 3'(y);
        tick();
        rd_en = 1'b0;
        chk({tag, "_lat0"}, 32'(rd_valid), 32'd0);
        tick();
        chk({tag, "_lat1"}, 32'(rd_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_pix"}, 32'(rd_pix), 32'(exp));
    endtask

    initial begin
        int busy_cnt;
        int ready_bad;

        rst = 1'b1; wr_valid = 1'b0; wr_eof = 1'b0; wr_x = '0; wr_y = '0; wr_pix = '0;
        rd_en = 1'b0; rd_x = '0; rd_y = '0; rd_vsync = 1'b0;
        clr_start = 1'b0; clr_color = '0;
        tick();
        tick();
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_pix", 32'(rd_pix), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_pending", 32'(swap_pending), 32'd0);
        chk("rst_drop", 32'(frame_drop), 32'd0);
        chk("rst_oob", 32'(oob_err), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);

        // First frame into bank 1, then swap it to the front.
        wr(5, 3, 'hABC, 1'b1);
        chk("f1_pending", 32'(swap_pending), 32'd1);
        chk("f1_no_drop", 32'(frame_drop), 32'd0);
        vsync();
        chk("f1_swapped", 32'(swap_pending), 32'd0);
        rd_chk("f1_read", 5, 3, 'hABC);

        // Second frame lands in the back bank; front stays until vsync.
        wr(5, 3, 'h5A5, 1'b1);
        chk("f2_pending", 32'(swap_pending), 32'd1);
        rd_chk("f2_old_front", 5, 3, 'hABC);
        vsync();
        chk("f2_swapped", 32'(swap_pending), 32'd0);
        rd_chk("f2_new_front", 5, 3, 'h5A5);

        // Two frame ends before a vsync: one drop pulse, newest data wins.
        wr(1, 1, 'h222, 1'b1);
        chk("drop_first_none", 32'(frame_drop), 32'd0);
        wr(1, 1, 'h333, 1'b1);
        chk("drop_pulse", 32'(frame_drop), 32'd1);
        chk("drop_pending", 32'(swap_pending), 32'd1);
        tick();
        chk("drop_one_cycle", 32'(frame_drop), 32'd0);
        vsync();
        rd_chk("drop_newest", 1, 1, 'h333);

        // eof and vsync together with nothing pending: no swap yet.
        rd_vsync = 1'b1;
        wr(2, 2, 'h444, 1'b1);
        rd_vsync = 1'b0;
        chk("same_cyc_pending", 32'(swap_pending), 32'd1);
        rd_chk("same_cyc_front_kept", 1, 1, 'h333);
        vsync();
        rd_chk("same_cyc_after_vsync", 2, 2, 'h444);

        // Clear back bank (bank 1) while a write is held off.
        clr_color = 12'h0F0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        chk("clr_busy_start", 32'(clr_busy), 32'd1);
        chk("clr_wr_ready_low", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1; wr_x = 3'd0; wr_y = 3'd0; wr_pix = 12'hFFF;
        busy_cnt  = 1;
        ready_bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!clr_busy) break;
            busy_cnt++;
            if (wr_ready) ready_bad++;
        end
        wr_valid = 1'b0;
        chk("clr_busy_cycles", 32'(busy_cnt), 32'(N));
        chk("clr_ready_during", 32'(ready_bad), 32'd0);
        chk("clr_ready_back", 32'(wr_ready), 32'd1);

        // Out-of-range write with eof: not stored, flags oob, still ends the frame.
        chk("oob_clear_before", 32'(oob_err), 32'd0);
        wr(6, 0, 'hFFF, 1'b1);
        chk("oob_wr_flag", 32'(oob_err), 32'd1);
        chk("oob_wr_pending", 32'(swap_pending), 32'd1);
        vsync();

        // Pipelined sweep of the cleared bank, one read per cycle.
        for (int i = 0; i < N + 2; i++) begin
            rd_en = (i < N);
            rd_x  = 3'(i % H_RES);
            rd_y  = 3'(i / H_RES);
            tick();
            if (i >= 2) begin
                chk($sformatf("clr_word%0d_valid", i - 2), 32'(rd_valid), 32'd1);
                chk($sformatf("clr_word%0d_pix", i - 2), 32'(rd_pix), 32'h0F0);
            end
        end
        rd_en = 1'b0;

        rd_chk("oob_rd", 0, 5, 0);
        tick();
        tick();
        chk("oob_sticky", 32'(oob_err), 32'd1);

        // Reset in the middle of a clear of bank 0.
        clr_color = 12'h00F;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_busy_before", 32'(clr_busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_busy_in_rst", 32'(clr_busy), 32'd0);
        chk("abort_ready_in_rst", 32'(wr_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("abort_busy_after", 32'(clr_busy), 32'd0);
        chk("abort_ready_after", 32'(wr_ready), 32'd1);
        chk("abort_oob_cleared", 32'(oob_err), 32'd0);
        chk("abort_pending", 32'(swap_pending), 32'd0);
        rd_chk("abort_front0_untouched", 5, 3, 'h5A5);
        rd_chk("abort_partial_fill", 0, 0, 'h00F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
